// File: rtl/phy_rx_link_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_defs (package)
// Purpose  : Shared constants for the PHY receive link controller.
// Revision : 1.0 - initial release
// ============================================================================
package phy_rx_defs;

    localparam int          CNT_W              = 4;
    localparam logic [7:0]  COM_SYMBOL_DEFAULT = 8'hBC;

    localparam logic [1:0]  ST_RESET  = 2'd0;
    localparam logic [1:0]  ST_SEARCH = 2'd1;
    localparam logic [1:0]  ST_ACTIVE = 2'd2;

    // Counter value at which the next qualifying event completes a run of n.
    function automatic logic [CNT_W-1:0] cnt_last(input int n);
        return CNT_W'(n - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_rx_link_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : Saturating up-counter with synchronous clear and increment enable.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/phy_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_link_ctrl
// Purpose  : Comma-based link sync, payload qualification and loss detection.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_link_ctrl
    import phy_rx_defs::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYMBOL_DEFAULT,
    parameter int         COM_COUNT  = 4,
    parameter int         LOSS_COUNT = 8
) (
    input  logic        clk_4f,
    input  logic        reset,
    input  logic [7:0]  data_in,
    input  logic        valid_in,
    output logic [7:0]  data_out,
    output logic        valid_out,
    output logic        active,
    output logic        idle_out,
    output logic [1:0]  state,
    output logic [15:0] payload_count
);

    localparam logic [CNT_W-1:0] c_com_last  = cnt_last(COM_COUNT);
    localparam logic [CNT_W-1:0] c_loss_last = cnt_last(LOSS_COUNT);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [7:0]       r_data_out;
    logic             r_valid_out;
    logic             r_active;
    logic             r_idle_out;
    logic [15:0]      r_payload_count;
    logic [CNT_W-1:0] w_com_cnt;
    logic [CNT_W-1:0] w_loss_cnt;
    logic             w_is_com;
    logic             w_is_payload;
    logic             w_com_done;
    logic             w_loss_done;
    logic             w_emit;

    assign w_is_com     = valid_in && (data_in == COM_SYMBOL);
    assign w_is_payload = valid_in && (data_in != COM_SYMBOL);
    assign w_com_done   = (r_state == ST_SEARCH) && w_is_com && (w_com_cnt == c_com_last);
    assign w_loss_done  = (r_state == ST_ACTIVE) && !valid_in && (w_loss_cnt == c_loss_last);
    assign w_emit       = (r_state == ST_ACTIVE) && w_is_payload;

    // Both counters clear on reaching their target so a fresh run starts at zero.
    sat_counter #(.WIDTH(CNT_W)) u_com_cnt (
        .clk     (clk_4f),
        .rst     (reset),
        .i_clr   ((r_state != ST_SEARCH) || !w_is_com || w_com_done),
        .i_inc   (w_is_com),
        .o_count (w_com_cnt)
    );

    sat_counter #(.WIDTH(CNT_W)) u_loss_cnt (
        .clk     (clk_4f),
        .rst     (reset),
        .i_clr   ((r_state != ST_ACTIVE) || valid_in || w_loss_done),
        .i_inc   (!valid_in),
        .o_count (w_loss_cnt)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RESET:  w_state_nxt = ST_SEARCH;
            ST_SEARCH: if (w_com_done)  w_state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (w_loss_done) w_state_nxt = ST_SEARCH;
            default:   w_state_nxt = ST_SEARCH;
        endcase
    end

    always_ff @(posedge clk_4f) begin
        if (reset) begin
            r_state         <= ST_RESET;
            r_data_out      <= 8'h00;
            r_valid_out     <= 1'b0;
            r_active        <= 1'b0;
            r_idle_out      <= 1'b1;
            r_payload_count <= 16'h0000;
        end else begin
            r_state     <= w_state_nxt;
            r_active    <= (w_state_nxt == ST_ACTIVE);
            r_valid_out <= w_emit;
            r_idle_out  <= !w_emit;
            if (w_emit) begin
                r_data_out <= data_in;
            end
            // Count survives loss of sync and restarts only on the next acquisition.
            if (w_com_done) begin
                r_payload_count <= 16'h0000;
            end else if (w_emit) begin
                r_payload_count <= r_payload_count + 16'h0001;
            end
        end
    end

    assign state         = r_state;
    assign data_out      = r_data_out;
    assign valid_out     = r_valid_out;
    assign active        = r_active;
    assign idle_out      = r_idle_out;
    assign payload_count = r_payload_count;

endmodule
`default_nettype wire

// File: tb/tb_phy_rx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phy_rx_link_ctrl
// Purpose  : Directed and randomized bench for phy_rx_link_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phy_rx_link_ctrl;

    localparam logic [7:0] COM        = 8'hBC;
    localparam int         COM_COUNT  = 4;
    localparam int         LOSS_COUNT = 8;

    logic        clk_4f = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic [7:0]  data_in = 8'h00;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        active;
    logic        idle_out;
    logic [1:0]  state;
    logic [15:0] payload_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: 0 = reset, 1 = searching, 2 = synchronised
    int         m_mode   = 0;
    int         m_commas = 0;
    int         m_misses = 0;
    int         m_count  = 0;
    logic [7:0] m_dout   = 8'h00;
    logic       m_vout   = 1'b0;

    phy_rx_link_ctrl #(
        .COM_SYMBOL (COM),
        .COM_COUNT  (COM_COUNT),
        .LOSS_COUNT (LOSS_COUNT)
    ) dut (
        .clk_4f        (clk_4f),
        .reset         (reset),
        .data_in       (data_in),
        .valid_in      (valid_in),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .active        (active),
        .idle_out      (idle_out),
        .state         (state),
        .payload_count (payload_count)
    );

    always #5 clk_4f = ~clk_4f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_step(input logic r, input logic v, input logic [7:0] d);
        m_vout = 1'b0;
        if (r) begin
            m_mode = 0; m_commas = 0; m_misses = 0; m_count = 0; m_dout = 8'h00;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (v && d == COM) begin
                m_commas++;
                if (m_commas == COM_COUNT) begin
                    m_mode = 2; m_commas = 0; m_count = 0;
                end
            end else begin
                m_commas = 0;
            end
        end else begin
            if (v) begin
                m_misses = 0;
                if (d != COM) begin
                    m_vout = 1'b1; m_dout = d; m_count = (m_count + 1) % 65536;
                end
            end else begin
                m_misses++;
                if (m_misses == LOSS_COUNT) begin
                    m_mode = 1; m_misses = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic v, input logic [7:0] d);
        @(negedge clk_4f);
        reset = r; valid_in = v; data_in = d;
        @(posedge clk_4f);
        model_step(r, v, d);
        #1;
        check("state", 32'(state), 32'(m_mode));
        check("active", 32'(active), 32'(m_mode == 2));
        check("valid_out", 32'(valid_out), 32'(m_vout));
        check("idle_out", 32'(idle_out), 32'(!m_vout));
        check("data_out", 32'(data_out), 32'(m_dout));
        check("payload_count", 32'(payload_count), 32'(m_count));
    endtask

    task automatic do_reset();
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic sync();
        repeat (COM_COUNT) cyc(1'b0, 1'b1, COM);
    endtask

    initial begin
        logic [7:0] d;
        int mode;

        // Reset release and acquisition
        do_reset();
        check("reset_state_search", 32'(state), 32'd1);
        sync();
        check("active_after_sync", 32'(active), 32'd1);

        // Broken comma run
        do_reset();
        repeat (3) cyc(1'b0, 1'b1, COM);
        cyc(1'b0, 1'b1, 8'h55);
        check("no_sync_on_break", 32'(active), 32'd0);
        sync();
        check("sync_after_break", 32'(active), 32'd1);

        // Payload with filler
        cyc(1'b0, 1'b1, 8'h01);
        cyc(1'b0, 1'b1, COM);
        cyc(1'b0, 1'b1, 8'h02);
        cyc(1'b0, 1'b1, 8'h03);
        check("payload_count_3", 32'(payload_count), 32'd3);

        // Loss of signal boundary
        repeat (LOSS_COUNT - 1) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, COM);
        check("still_active", 32'(active), 32'd1);
        repeat (LOSS_COUNT) cyc(1'b0, 1'b0, 8'h00);
        check("lost_sync", 32'(active), 32'd0);
        check("count_held", 32'(payload_count), 32'd3);
        sync();
        check("count_cleared", 32'(payload_count), 32'd0);

        // Mid-stream reset
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        cyc(1'b1, 1'b1, 8'h33);
        check("midreset_data", 32'(data_out), 32'd0);
        check("midreset_state", 32'(state), 32'd0);
        cyc(1'b0, 1'b1, 8'h44);

        // Randomized traffic in bursts
        mode = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 12 == 0) mode = $urandom_range(0, 3);
            d = 8'($urandom);
            case (mode)
                0: cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                       ($urandom_range(0, 9) != 0) ? COM : d);
                1: cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0, d);
                2: cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, d);
                default: cyc($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                             $urandom_range(0, 1) == 1 ? COM : d);
            endcase
        end

        // Payload counter wrap
        do_reset();
        sync();
        for (int i = 0; i < 65535; i++) begin
            d = 8'($urandom);
            if (d == COM) d = 8'h00;
            cyc(1'b0, 1'b1, d);
        end
        check("count_ffff", 32'(payload_count), 32'hFFFF);
        cyc(1'b0, 1'b1, 8'hA5);
        check("count_wrap0", 32'(payload_count), 32'h0);
        check("wrap_byte_out", 32'(valid_out), 32'd1);
        cyc(1'b0, 1'b1, 8'h5A);
        check("count_wrap1", 32'(payload_count), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
